// File: rtl/mmio_io_responder.sv
// mmio_io_responder: IO-space responder beside the dual-port RAM.
// Accesses with addr MSB set hit four registers selected by addr[1:0]:
// debounced switches, LED register, button press edges (W1C) and an optional timer.
// Load data is registered, so it has the same 1-cycle latency as the RAM.
// Optional feature macro: MMIO_TIMER_EN (builds the timer and its prescaler).
module mmio_io_responder #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int BTN_WIDTH      = 4,
    parameter int DB_CYCLES      = 50000,
    parameter int TIMER_PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] sw,
    input  logic [BTN_WIDTH-1:0]  btn,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  io_hit_q,
    output logic [DATA_WIDTH-1:0] leds
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    logic                  hit, ld, st;
    logic [1:0]            sel;
    logic                  db_tick;
    logic [DBW-1:0]        db_cnt_q, db_cnt_d;
    logic [DATA_WIDTH-1:0] sw_s1_q, sw_s2_q, sw_smp_q, sw_smp_d, sw_stb_q, sw_stb_d;
    logic [BTN_WIDTH-1:0]  btn_s1_q, btn_s2_q, btn_smp_q, btn_smp_d, btn_stb_q, btn_stb_d;
    logic [BTN_WIDTH-1:0]  btn_rise, edge_clr, edge_q, edge_d;
    logic [DATA_WIDTH-1:0] leds_q, leds_d, rd_q, rd_d, rd_mux, timer_val;
    logic                  hit_q, hit_d;

    // Middle address bits only create aliases of the four registers.
    logic unused_addr;
    assign unused_addr = ^addr[ADDR_WIDTH-2:2];

    // Access decode.
    always_comb begin
        hit = addr[ADDR_WIDTH-1];
        ld  = hit & ~write;
        st  = hit & write;
        sel = addr[1:0];
    end

    // Debounce: shared tick; a level is accepted when two consecutive ticks see the same vector.
    always_comb begin
        db_tick   = (db_cnt_q == DB_LAST);
        db_cnt_d  = db_tick ? '0 : db_cnt_q + 1'b1;
        sw_smp_d  = sw_smp_q;
        sw_stb_d  = sw_stb_q;
        btn_smp_d = btn_smp_q;
        btn_stb_d = btn_stb_q;
        if (db_tick) begin
            sw_smp_d  = sw_s2_q;
            btn_smp_d = btn_s2_q;
            if (sw_s2_q == sw_smp_q)
                sw_stb_d = sw_s2_q;
            if (btn_s2_q == btn_smp_q)
                btn_stb_d = btn_s2_q;
        end
        btn_rise = btn_stb_d & ~btn_stb_q;
    end

`ifdef MMIO_TIMER_EN
    localparam logic [15:0] PRE_LAST = 16'(TIMER_PRESCALE - 1);
    logic [15:0]           presc_q, presc_d;
    logic [DATA_WIDTH-1:0] timer_q, timer_d;

    // Free-running timer; a store reloads it and restarts the prescaler.
    always_comb begin
        presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
        timer_d = (presc_q == PRE_LAST) ? timer_q + 1'b1 : timer_q;
        if (st && sel == 2'd3) begin
            timer_d = wr_data;
            presc_d = '0;
        end
    end

    // Timer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            timer_q <= '0;
        end else begin
            presc_q <= presc_d;
            timer_q <= timer_d;
        end
    end

    assign timer_val = timer_q;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMER_PRESCALE < 1);
    assign timer_val  = '0;
`endif

    // Register updates and load mux; loads see state from before this edge's updates.
    always_comb begin
        leds_d   = (st && sel == 2'd1) ? wr_data : leds_q;
        edge_clr = (st && sel == 2'd2) ? wr_data[BTN_WIDTH-1:0] : '0;
        edge_d   = (edge_q & ~edge_clr) | btn_rise;
        case (sel)
            2'd0:    rd_mux = sw_stb_q;
            2'd1:    rd_mux = leds_q;
            2'd2:    rd_mux = DATA_WIDTH'(edge_q);
            default: rd_mux = timer_val;
        endcase
        rd_d  = ld ? rd_mux : rd_q;
        hit_d = ld;
    end

    // State registers; reset overrides any same-edge access.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q  <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            sw_smp_q  <= '0;
            sw_stb_q  <= '0;
            btn_s1_q  <= '0;
            btn_s2_q  <= '0;
            btn_smp_q <= '0;
            btn_stb_q <= '0;
            edge_q    <= '0;
            leds_q    <= '0;
            rd_q      <= '0;
            hit_q     <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            sw_s1_q   <= sw;
            sw_s2_q   <= sw_s1_q;
            sw_smp_q  <= sw_smp_d;
            sw_stb_q  <= sw_stb_d;
            btn_s1_q  <= btn;
            btn_s2_q  <= btn_s1_q;
            btn_smp_q <= btn_smp_d;
            btn_stb_q <= btn_stb_d;
            edge_q    <= edge_d;
            leds_q    <= leds_d;
            rd_q      <= rd_d;
            hit_q     <= hit_d;
        end
    end

    assign rd_data  = rd_q;
    assign io_hit_q = hit_q;
    assign leds     = leds_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Bench for mmio_io_responder: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a history-based model.
module tb_mmio_io_responder;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int BW = 4;
    localparam int DB = 4;
    localparam int TP = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          write = 1'b0;
    logic [DW-1:0] sw = 16'hFFFF;
    logic [BW-1:0] btn = 4'hF;
    logic [DW-1:0] rd_data;
    logic          io_hit_q;
    logic [DW-1:0] leds;

    mmio_io_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BTN_WIDTH(BW),
        .DB_CYCLES(DB), .TIMER_PRESCALE(TP)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data), .write(write),
        .sw(sw), .btn(btn), .rd_data(rd_data), .io_hit_q(io_hit_q), .leds(leds)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Inputs are kept as a history: index 0 is the value seen at the latest edge.
    // A debounced level is accepted at a tick edge n when the input seen at n-2
    // equals the input seen at n-2-DB (two ticks agreeing after the 2-flop sync).
    logic [DW-1:0] m_leds, m_rd, m_sw_stb, m_tbase_v;
    logic [BW-1:0] m_btn_stb, m_edge;
    logic          m_hit;
    int            m_n, m_tbase_n;
    bit            chk_en = 1'b0;
    logic [DW-1:0] sw_h[$];
    logic [BW-1:0] btn_h[$];

    // Timer value after the most recent modelled edge.
    function automatic logic [DW-1:0] timer_now();
`ifdef MMIO_TIMER_EN
        return m_tbase_v + DW'((m_n - m_tbase_n) / TP);
`else
        return '0;
`endif
    endfunction

    always @(posedge clk) begin : model
        logic [DW-1:0] rv;
        logic [BW-1:0] new_b, clr;
        if (reset) begin
            m_leds = '0; m_rd = '0; m_sw_stb = '0; m_btn_stb = '0; m_edge = '0;
            m_hit = 1'b0; m_n = 0; m_tbase_n = 0; m_tbase_v = '0;
            sw_h.delete();
            btn_h.delete();
            for (int i = 0; i < DB + 3; i++) begin
                sw_h.push_front('0);
                btn_h.push_front('0);
            end
            chk_en = 1'b1;
        end else begin
            case (addr[1:0])
                2'd0:    rv = m_sw_stb;
                2'd1:    rv = m_leds;
                2'd2:    rv = DW'(m_edge);
                default: rv = timer_now();
            endcase
            m_hit = addr[AW-1] && !write;
            if (m_hit) m_rd = rv;
            m_n++;
            sw_h.push_front(sw);   void'(sw_h.pop_back());
            btn_h.push_front(btn); void'(btn_h.pop_back());
            new_b = m_btn_stb;
            if (m_n % DB == 0) begin
                if (sw_h[2] == sw_h[2 + DB]) m_sw_stb = sw_h[2];
                if (btn_h[2] == btn_h[2 + DB]) new_b = btn_h[2];
            end
            clr = '0;
            if (addr[AW-1] && write) begin
                case (addr[1:0])
                    2'd1: m_leds = wr_data;
                    2'd2: clr = wr_data[BW-1:0];
                    2'd3: begin
`ifdef MMIO_TIMER_EN
                        m_tbase_n = m_n;
                        m_tbase_v = wr_data;
`endif
                    end
                    default: ;
                endcase
            end
            m_edge = (m_edge & ~clr) | (new_b & ~m_btn_stb);
            m_btn_stb = new_b;
        end
    end

    // Continuous comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("io_hit_q", 32'(io_hit_q), 32'(m_hit));
            check("leds", 32'(leds), 32'(m_leds));
            check("rd_data", 32'(rd_data), 32'(m_rd));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic access(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
        @(negedge clk);
        addr = a; wr_data = d; write = w;
        @(posedge clk);
        #1;
        addr = '0; wr_data = '0; write = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int r;
        logic [AW-1:0] ra;

        // 1: reset with inputs active
        repeat (2) @(posedge clk);
        #1;
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_io_hit", 32'(io_hit_q), 32'h0);
        reset = 1'b0;
        access(16'h8002, '0, 1'b0);
        check("first_edge_load", 32'(rd_data), 32'h0000);

        // 2: LED store / load, non-hit store
        access(16'h8001, 16'h00A5, 1'b1);
        check("led_store", 32'(leds), 32'h00A5);
        access(16'h8001, '0, 1'b0);
        check("led_load", 32'(rd_data), 32'h00A5);
        check("led_load_hit", 32'(io_hit_q), 32'h1);
        access(16'h7FFF, 16'hFFFF, 1'b1);
        check("nonhit_leds", 32'(leds), 32'h00A5);
        check("nonhit_hit", 32'(io_hit_q), 32'h0);

        // 3: switch debounce and glitch rejection
        sw = 16'h0000;
        idle(12);
        sw = 16'h1234;
        idle(10);
        access(16'h8000, '0, 1'b0);
        check("sw_settle", 32'(rd_data), 32'h1234);
        sw = 16'hFFFF;
        idle(3);
        sw = 16'h1234;
        for (int i = 0; i < 15; i++) begin
            access(16'h8000, '0, 1'b0);
            check("sw_glitch", 32'(rd_data), 32'h1234);
        end

        // 4: button edge capture, alias read, W1C, set-wins race
        btn = '0;
        idle(12);
        access(16'h8002, 16'h000F, 1'b1);
        btn = 4'h4;
        idle(12);
        access(16'h8802, '0, 1'b0);
        check("edge_alias", 32'(rd_data), 32'h0004);
        btn = '0;
        access(16'h8002, 16'h0004, 1'b1);
        access(16'h8002, '0, 1'b0);
        check("edge_w1c", 32'(rd_data), 32'h0000);
        idle(12);
        btn = 4'h4;
        r = m_n + 3 + DB;
        r = ((r + DB - 1) / DB) * DB;
        idle(r - 1 - m_n);
        access(16'h8002, 16'h0004, 1'b1);
        access(16'h8002, '0, 1'b0);
        check("edge_set_wins", 32'(rd_data), 32'h0004);
        btn = '0;

        // 5: timer wrap (reads 0 with or without the timer)
        access(16'h8003, 16'hFFFE, 1'b1);
        idle(4);
        access(16'h8003, '0, 1'b0);
        check("timer_wrap", 32'(rd_data), 32'h0000);

        // 6: reset beats a simultaneous store
        access(16'h8001, 16'h1111, 1'b1);
        check("led_1111", 32'(leds), 32'h1111);
        @(negedge clk);
        reset = 1'b1; addr = 16'h8001; wr_data = 16'h2222; write = 1'b1;
        @(posedge clk);
        #1;
        check("reset_wins", 32'(leds), 32'h0000);
        reset = 1'b0; addr = '0; wr_data = '0; write = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) sw = DW'($urandom);
            if ($urandom_range(0, 9) == 0) btn = BW'($urandom);
            ra = AW'($urandom);
            ra[AW-1] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                @(negedge clk);
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            access(ra, DW'($urandom), 1'($urandom));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
